// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned PC8_OFS = 8;

  typedef enum logic [2:0] {
    S_BOOT,
    S_RUN,
    S_HOLD,
    S_REDIR,
    S_HALT
  } fetch_state_t;

  // One fetched instruction paired with its byte address.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_word_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an {instr, pc} word that decode refused.
// The offered word is the skid entry when full, else the live ROM response.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        rsp_vld,
  input  fetch_word_t rsp_word,
  input  logic        id_ready,
  output logic        out_vld_c,
  output fetch_word_t out_word_c,
  output logic        skid_nxt_c
);

  logic        skid_vld_q;
  fetch_word_t skid_word_q;
  logic        capture;

  // Capture decision and the combinational offer mux.
  always_comb begin
    capture    = ~skid_vld_q & rsp_vld & ~id_ready;
    skid_nxt_c = (skid_vld_q & ~id_ready) | capture;
    out_vld_c  = skid_vld_q | rsp_vld;
    out_word_c = skid_vld_q ? skid_word_q : rsp_word;
  end

  // Skid entry state; a flush drops whatever is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_q  <= 1'b0;
      skid_word_q <= '0;
    end else if (flush) begin
      skid_vld_q  <= 1'b0;
    end else begin
      skid_vld_q <= skid_nxt_c;
      if (capture) skid_word_q <= rsp_word;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the registered-read ROM and
// hands {instr, pc} to decode over valid/ready with a 1-entry skid buffer.
// Optional feature macro: FETCH_PERF_CNT_EN adds handshake/stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0,
  parameter int unsigned       ROM_WORDS = 23
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Dir,
  input  logic [31:0] Instruccion,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        oob
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(ROM_WORDS * PC_STEP);

  fetch_state_t      state_q;
  logic              rsp_vld_q;
  logic [ADDR_W-1:0] rsp_pc_q;
  logic              offer_vld;
  fetch_word_t       offer_word;
  fetch_word_t       rsp_word;
  logic              skid_nxt;
  logic              can_issue;
  logic              at_limit;
  logic              issue;
  logic              halt_set;

  // Issue gating: stall, halt and redirect all block a new ROM request.
  always_comb begin
    rsp_word  = '{instr: Instruccion, pc: rsp_pc_q};
    can_issue = ~skid_nxt & ~oob & ~br_taken;
    at_limit  = (Dir >= PC_LIMIT);
    issue     = can_issue & ~at_limit;
    halt_set  = can_issue & at_limit;
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (reset),
    .flush      (br_taken),
    .rsp_vld    (rsp_vld_q),
    .rsp_word   (rsp_word),
    .id_ready   (id_ready),
    .out_vld_c  (offer_vld),
    .out_word_c (offer_word),
    .skid_nxt_c (skid_nxt)
  );

  // Decode-facing view; a redirect squashes whatever is offered this cycle.
  always_comb begin
    id_valid = offer_vld & ~br_taken;
    id_instr = offer_word.instr;
    id_pc    = offer_word.pc;
    id_pc8   = offer_word.pc + ADDR_W'(PC8_OFS);
  end

  // PC, in-flight response tracking, halt flag and the fetch FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Dir       <= RESET_PC;
      rsp_vld_q <= 1'b0;
      rsp_pc_q  <= '0;
      oob       <= 1'b0;
      state_q   <= S_BOOT;
    end else if (br_taken) begin
      Dir       <= br_target & ~ADDR_W'(3);
      rsp_vld_q <= 1'b0;
      oob       <= 1'b0;
      state_q   <= S_REDIR;
    end else begin
      rsp_vld_q <= issue;
      if (issue) begin
        rsp_pc_q <= Dir;
        Dir      <= Dir + ADDR_W'(PC_STEP);
      end
      if (halt_set) begin
        oob     <= 1'b1;
        state_q <= S_HALT;
      end else begin
        case (state_q)
          S_BOOT:  if (issue) state_q <= S_RUN;
          S_RUN:   if (skid_nxt) state_q <= S_HOLD;
          S_HOLD:  if (!skid_nxt) state_q <= S_RUN;
          S_REDIR: state_q <= S_RUN;
          S_HALT:  state_q <= S_HALT;
          default: state_q <= S_BOOT;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Accepted-handshake and back-pressure cycle counters, wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (id_valid & id_ready)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_valid & ~id_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a registered-read instruction ROM model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] Dir;
  logic [31:0] instruccion;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        oob;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks;
  int failures;

  logic [31:0] rom [0:22];
  logic        s_valid;
  logic [31:0] s_pc, s_instr, s_pc8, s_dir;
  logic        s_oob;
  logic [31:0] acc_pc[$];
  logic [31:0] acc_instr[$];
  int          tot_acc;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .Dir         (Dir),
    .Instruccion (instruccion),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc8      (id_pc8),
    .oob         (oob)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd92) return rom[a[6:2]];
    return 32'hDEADBEEF;
  endfunction

  // Instruction ROM: one cycle read latency.
  always @(posedge clk) instruccion <= rom_word(Dir);

  // Advance one cycle: sample outputs at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    s_valid = id_valid; s_pc = id_pc; s_instr = id_instr; s_pc8 = id_pc8;
    s_dir = Dir; s_oob = oob;
    if (id_valid === 1'b1 && id_ready === 1'b1) begin
      acc_pc.push_back(id_pc);
      acc_instr.push_back(id_instr);
      tot_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; id_ready = 1'b1; br_taken = 1'b0; br_target = '0;
    tot_acc = 0;
    repeat (3) cycle();
    checks++;
    if (s_valid !== 1'b0 || s_dir !== 32'h0 || s_oob !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b dir=%h oob=%b, required 0/00000000/0", s_valid, s_dir, s_oob);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL boot_cycle: valid=%b, required 0", s_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'(4 * i) || s_instr !== rom_word(32'(4 * i))
          || s_pc8 !== 32'(4 * i + 8)) begin
        failures++;
        $display("FAIL reset_stream[%0d]: valid=%b pc=%h instr=%h pc8=%h, required 1/%h/%h/%h",
                 i, s_valid, s_pc, s_instr, s_pc8, 32'(4 * i), rom_word(32'(4 * i)), 32'(4 * i + 8));
      end
    end
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    id_ready = 1'b1;
    while (!(id_valid === 1'b1 && id_pc === 32'h10) && n < 20) begin cycle(); n++; end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL stall_reach: pc 00000010 never offered"); end
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'h10 || s_instr !== 32'hE1874002 || s_dir !== 32'h14) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h dir=%h, required 1/00000010/e1874002/00000014",
                 i, s_valid, s_pc, s_instr, s_dir);
      end
    end
    id_ready = 1'b1;
    acc_pc.delete(); acc_instr.delete();
    repeat (4) cycle();
    checks++;
    if (acc_pc.size() < 3 || acc_pc[0] !== 32'h10 || acc_pc[1] !== 32'h14 || acc_pc[2] !== 32'h18
        || acc_instr[1] !== 32'hE0035004) begin
      failures++;
      $display("FAIL stall_release: accepted %0d words first=%h second=%h, required 00000010,00000014(e0035004),00000018",
               acc_pc.size(), acc_pc.size() > 0 ? acc_pc[0] : 32'hX, acc_pc.size() > 1 ? acc_pc[1] : 32'hX);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd3 || perf_fetch_cnt !== 32'(tot_acc)) begin
      failures++;
      $display("FAIL perf_cnt: stall=%0d fetch=%0d, required 3/%0d", perf_stall_cnt, perf_fetch_cnt, tot_acc);
    end
`endif
  endtask

  task automatic test_branch();
    int n;
    id_ready = 1'b1;
    repeat (2) cycle();
    br_taken = 1'b1; br_target = 32'h5A;
    cycle();
    checks++;
    if (s_valid !== 1'b0) begin failures++; $display("FAIL branch_squash: valid=%b, required 0", s_valid); end
    br_taken = 1'b0;
    acc_pc.delete(); acc_instr.delete();
    n = 0;
    while (acc_pc.size() == 0 && n < 6) begin cycle(); n++; end
    checks++;
    if (acc_pc.size() == 0 || acc_pc[0] !== 32'h58 || acc_instr[0] !== 32'hE5802064 || n != 2) begin
      failures++;
      $display("FAIL branch_target: got %0d words after %0d cycles first=%h, required 00000058/e5802064 after 2",
               acc_pc.size(), n, acc_pc.size() > 0 ? acc_pc[0] : 32'hX);
    end
  endtask

  task automatic test_oob();
    int n;
    n = 0;
    while (s_oob !== 1'b1 && n < 10) begin cycle(); n++; end
    checks++;
    if (s_oob !== 1'b1 || s_dir !== 32'h5C) begin
      failures++;
      $display("FAIL oob_set: oob=%b dir=%h, required 1/0000005c", s_oob, s_dir);
    end
    repeat (5) begin
      cycle();
      checks++;
      if (s_valid !== 1'b0 || s_dir !== 32'h5C || s_oob !== 1'b1) begin
        failures++;
        $display("FAIL oob_hold: valid=%b dir=%h oob=%b, required 0/0000005c/1", s_valid, s_dir, s_oob);
      end
    end
    checks++;
    if (acc_pc.size() != 1) begin
      failures++;
      $display("FAIL oob_no_extra: %0d words delivered after target, required 1", acc_pc.size());
    end
    br_taken = 1'b1; br_target = 32'h0;
    cycle();
    br_taken = 1'b0;
    cycle();
    checks++;
    if (s_oob !== 1'b0) begin failures++; $display("FAIL oob_clear: oob=%b, required 0", s_oob); end
    cycle();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== 32'hE04F000F) begin
      failures++;
      $display("FAIL oob_restart: valid=%b pc=%h instr=%h, required 1/00000000/e04f000f", s_valid, s_pc, s_instr);
    end
  endtask

  task automatic test_branch_in_stall();
    int n;
    id_ready = 1'b1;
    repeat (3) cycle();
    id_ready = 1'b0;
    repeat (2) cycle();
    br_taken = 1'b1; br_target = 32'h21;
    cycle();
    checks++;
    if (s_valid !== 1'b0) begin failures++; $display("FAIL stall_branch_squash: valid=%b, required 0", s_valid); end
    br_taken = 1'b0; id_ready = 1'b1;
    acc_pc.delete(); acc_instr.delete();
    n = 0;
    while (acc_pc.size() == 0 && n < 6) begin cycle(); n++; end
    checks++;
    if (acc_pc.size() == 0 || acc_pc[0] !== 32'h20 || acc_instr[0] !== rom_word(32'h20)) begin
      failures++;
      $display("FAIL stall_branch_target: first=%h, required 00000020",
               acc_pc.size() > 0 ? acc_pc[0] : 32'hX);
    end
  endtask

  task automatic test_reset_mid_stall();
    id_ready = 1'b1;
    repeat (2) cycle();
    id_ready = 1'b0;
    repeat (2) cycle();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || Dir !== 32'h0 || oob !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b dir=%h oob=%b, required 0/00000000/0", id_valid, Dir, oob);
    end
    test_reset();
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_pc, tgt;
    logic        prev_stall, br;
    exp_pc = '0; prev_pc = '0; prev_stall = 1'b0;
    for (int i = 0; i < 640; i++) begin
      if (i < 600) begin
        id_ready = ($urandom_range(0, 3) != 0);
        br = (i == 0) || ($urandom_range(0, 39) == 0);
      end else begin
        id_ready = 1'b1;
        br = 1'b0;
      end
      tgt = 32'($urandom_range(0, 91));
      br_taken = br; br_target = tgt;
      cycle();
      if (br) begin
        checks++;
        if (s_valid !== 1'b0) begin failures++; $display("FAIL rand_squash[%0d]: valid=%b, required 0", i, s_valid); end
        exp_pc = tgt & ~32'h3;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (s_valid !== 1'b1 || s_pc !== prev_pc) begin
            failures++;
            $display("FAIL rand_hold[%0d]: valid=%b pc=%h, required 1/%h", i, s_valid, s_pc, prev_pc);
          end
        end
        if (s_valid === 1'b1) begin
          checks++;
          if (s_pc >= 32'd92 || s_instr !== rom_word(s_pc) || s_pc8 !== s_pc + 32'd8) begin
            failures++;
            $display("FAIL rand_word[%0d]: pc=%h instr=%h pc8=%h, required in-rom/%h/%h",
                     i, s_pc, s_instr, s_pc8, rom_word(s_pc), s_pc + 32'd8);
          end
          if (id_ready) begin
            checks++;
            if (s_pc !== exp_pc) begin
              failures++;
              $display("FAIL rand_order[%0d]: pc=%h, required %h", i, s_pc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
          end
        end
        prev_stall = (s_valid === 1'b1) && !id_ready;
        prev_pc = s_pc;
      end
    end
    checks++;
    if (exp_pc !== 32'h5C || s_oob !== 1'b1 || s_dir !== 32'h5C) begin
      failures++;
      $display("FAIL rand_drain: next=%h oob=%b dir=%h, required 0000005c/1/0000005c", exp_pc, s_oob, s_dir);
    end
  endtask

  initial begin
    checks = 0; failures = 0; tot_acc = 0;
    for (int i = 0; i < 23; i++) rom[i] = 32'hE3A00000 | 32'(i);
    rom[0]  = 32'hE04F000F;
    rom[1]  = 32'hE2802005;
    rom[4]  = 32'hE1874002;
    rom[5]  = 32'hE0035004;
    rom[22] = 32'hE5802064;
    reset = 1'b0; id_ready = 1'b0; br_taken = 1'b0; br_target = '0;
    @(posedge clk); #1;
    test_reset();
    test_stall();
    test_branch();
    test_oob();
    test_branch_in_stall();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
